// File: rtl/adpll_nco.sv
// ---------------------------------------------------------------------------
// adpll_nco -- all-digital PLL built around a phase-accumulator NCO.
//
// The NCO adds a frequency word (fw) to a phase accumulator every i_clk
// cycle. o_gen is the inverted accumulator MSB, so it rises when the
// accumulator wraps.
//
// Each synchronised rising edge of i_rf samples the accumulator phase and
// drives a bang-bang proportional-plus-integral correction:
//   - the integral path nudges fw by i_step and clamps it to [FW_MIN, FW_MAX];
//   - the proportional path kicks the phase by i_step << KP_SHIFT.
//
// A lock detector counts consecutive edges whose phase falls inside a narrow
// window around the wrap point. A timeout drops lock when the reference
// disappears; the NCO then keeps free-running at the last fw.
//
// Ports:
//   i_clk   in   1       system clock, every register rises on it
//   i_rst   in   1       synchronous active-high reset
//   i_rf    in   1       asynchronous reference input
//   i_step  in   STEP_W  integral gain (fw adjustment per reference edge)
//   i_hold  in   1       1 = freeze fw and suppress the phase kick
//   o_gen   out  1       generated clock, ~acc MSB, registered
//   o_lock  out  1       lock indicator
//   o_fw    out  ACC_W   current frequency word
//   o_up    out  1       one-cycle pulse: NCO lagging, fw increased
//   o_dn    out  1       one-cycle pulse: NCO leading, fw decreased
// ---------------------------------------------------------------------------
module adpll_nco #(
    parameter int               ACC_W       = 24,
    parameter int               STEP_W      = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               KP_SHIFT    = 2,
    parameter logic [ACC_W-1:0] FW_INIT     = {4'b0000, 1'b1, {(ACC_W-5){1'b0}}},
    parameter logic [ACC_W-1:0] FW_MIN      = {{(ACC_W-1){1'b0}}, 1'b1},
    parameter logic [ACC_W-1:0] FW_MAX      = {1'b0, {(ACC_W-1){1'b1}}},
    parameter int               LOCK_BITS   = 4,
    parameter int               LOCK_CNT    = 16,
    parameter int               TO_W        = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rf,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_hold,
    output logic              o_gen,
    output logic              o_lock,
    output logic [ACC_W-1:0]  o_fw,
    output logic              o_up,
    output logic              o_dn
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    // Two guard bits: one for the carry of fw + step, one for the sign of
    // fw - step, so the clamp sees the true value before any wrap.
    localparam int EXT_W = ACC_W + 2;

    // Clamp an extended frequency word into [FW_MIN, FW_MAX].
    function automatic logic [ACC_W-1:0] clamp_fw(input logic signed [EXT_W-1:0] v);
        logic signed [EXT_W-1:0] lo;
        logic signed [EXT_W-1:0] hi;
        lo = signed'({2'b00, FW_MIN});
        hi = signed'({2'b00, FW_MAX});
        if (v < lo) begin
            return FW_MIN;
        end else if (v > hi) begin
            return FW_MAX;
        end else begin
            return v[ACC_W-1:0];
        end
    endfunction

    // Saturating increment of the lock counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_W'(LOCK_CNT)) begin
            return CNT_W'(LOCK_CNT);
        end else begin
            return c + CNT_W'(1);
        end
    endfunction

    // Registers
    logic [SYNC_STAGES-1:0] rf_sync_p0;  // metastability chain
    logic                   rf_prev_p1;  // previous synchronised level
    logic                   edge_p2;     // registered rising-edge pulse
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       fw;
    logic [CNT_W-1:0]       cnt;
    logic [TO_W-1:0]        tcnt;

    // Combinational next-state
    logic                     rf_synced;
    logic                     lag;
    logic                     act;
    logic signed [ACC_W-1:0]  kick_mag;
    logic signed [ACC_W-1:0]  kick;
    logic [ACC_W-1:0]         acc_nxt;
    logic signed [EXT_W-1:0]  fw_ext;
    logic signed [EXT_W-1:0]  step_ext;
    logic [ACC_W-1:0]         fw_nxt;
    logic [LOCK_BITS-1:0]     phase_top;
    logic                     in_win;
    logic                     to_hit;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [TO_W-1:0]          tcnt_nxt;
    logic                     lock_nxt;

    assign rf_synced = rf_sync_p0[SYNC_STAGES-1];

    // ---- stage p3: phase detector, loop filter and NCO update ----
    always_comb begin
        // Accumulator MSB set at the reference edge means the NCO has not
        // yet wrapped, i.e. it lags the reference.
        lag      = acc[ACC_W-1];
        act      = edge_p2 & ~i_hold;
        kick_mag = signed'(ACC_W'(i_step) << KP_SHIFT);
        kick     = '0;
        if (act) begin
            kick = lag ? kick_mag : -kick_mag;
        end
        acc_nxt = acc + fw + kick;

        fw_ext   = signed'({2'b00, fw});
        step_ext = signed'(EXT_W'(i_step));
        fw_nxt   = fw;
        if (act) begin
            fw_nxt = clamp_fw(lag ? (fw_ext + step_ext) : (fw_ext - step_ext));
        end
    end

    // ---- stage p3: lock detector and reference timeout ----
    always_comb begin
        phase_top = acc[ACC_W-1 -: LOCK_BITS];
        in_win    = (phase_top == '0) || (phase_top == '1);
        to_hit    = (tcnt == '1);
        cnt_nxt   = cnt;
        tcnt_nxt  = tcnt;
        lock_nxt  = o_lock;

        // A real edge wins over a timeout landing in the same cycle, so the
        // first edge after a reference outage already counts toward lock.
        if (edge_p2) begin
            tcnt_nxt = '0;
            if (in_win) begin
                cnt_nxt = sat_inc(cnt);
            end else begin
                cnt_nxt = '0;
            end
        end else if (to_hit) begin
            cnt_nxt = '0;
        end else begin
            tcnt_nxt = tcnt + TO_W'(1);
        end

        if ((edge_p2 && !in_win) || (!edge_p2 && to_hit)) begin
            lock_nxt = 1'b0;
        end else if (cnt == CNT_W'(LOCK_CNT)) begin
            lock_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rf_sync_p0 <= '0;
            rf_prev_p1 <= 1'b0;
            edge_p2    <= 1'b0;
            acc        <= '0;
            fw         <= FW_INIT;
            o_gen      <= 1'b1;
            o_up       <= 1'b0;
            o_dn       <= 1'b0;
            o_lock     <= 1'b0;
            cnt        <= '0;
            tcnt       <= '0;
        end else begin
            // ---- stage p0: reference synchroniser ----
            rf_sync_p0 <= {rf_sync_p0[SYNC_STAGES-2:0], i_rf};
            // ---- stage p1/p2: edge detection ----
            rf_prev_p1 <= rf_synced;
            edge_p2    <= rf_synced & ~rf_prev_p1;
            // ---- stage p3: NCO, loop filter, lock ----
            acc        <= acc_nxt;
            fw         <= fw_nxt;
            o_gen      <= ~acc_nxt[ACC_W-1];
            o_up       <= edge_p2 & lag;
            o_dn       <= edge_p2 & ~lag;
            cnt        <= cnt_nxt;
            tcnt       <= tcnt_nxt;
            o_lock     <= lock_nxt;
        end
    end

    assign o_fw = fw;

endmodule

// File: tb/tb_adpll_nco.sv
// ---------------------------------------------------------------------------
// tb_adpll_nco -- directed scoreboard bench for adpll_nco.
//
// Small configuration: ACC_W=16, FW_INIT=2048 (gen period 32 cycles).
// Every reference pulse pushes its expected up/dn/fw response. A negedge
// monitor pops one entry for each up/dn pulse the DUT emits.
//
// Timeline convention: "edge n" is the n-th i_clk rise after reset release.
// An i_rf rise driven just after edge m is processed at edge m+4, using the
// accumulator value left by edge m+3.
// ---------------------------------------------------------------------------
module tb_adpll_nco;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        rf   = 1'b0;
    logic        hold = 1'b0;
    logic [7:0]  step = 8'd0;
    logic        gen;
    logic        lock;
    logic [15:0] fw;
    logic        up;
    logic        dn;

    adpll_nco #(
        .ACC_W       (16),
        .STEP_W      (8),
        .SYNC_STAGES (2),
        .KP_SHIFT    (2),
        .FW_INIT     (16'd2048),
        .FW_MIN      (16'd1950),
        .FW_MAX      (16'd2100),
        .LOCK_BITS   (4),
        .LOCK_CNT    (16),
        .TO_W        (12)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_rf   (rf),
        .i_step (step),
        .i_hold (hold),
        .o_gen  (gen),
        .o_lock (lock),
        .o_fw   (fw),
        .o_up   (up),
        .o_dn   (dn)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic        up;
        logic        dn;
        logic [15:0] fw;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   now      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every up/dn pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (up === 1'b1 || dn === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: up=%0b dn=%0b fw=%0d, no pulse expected (t=%0t)",
                         up, dn, fw, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_up", 32'(up), 32'(mon_e.up));
                check("pulse_dn", 32'(dn), 32'(mon_e.dn));
                check("pulse_fw", 32'(fw), 32'(mon_e.fw));
            end
        end
    end

    task automatic step_to(input int n);
        while (now < n) begin
            @(posedge clk);
            #1;
            now++;
        end
    endtask

    // Raise i_rf just after edge m for two cycles and record the response.
    task automatic pulse(input int m, input logic [7:0] s, input logic h,
                         input logic eu, input logic ed, input logic [15:0] efw);
        exp_t e;
        step_to(m);
        step = s;
        hold = h;
        rf   = 1'b1;
        e.up = eu;
        e.dn = ed;
        e.fw = efw;
        sb_q.push_back(e);
        step_to(m + 2);
        rf = 1'b0;
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        check("rst_fw",   32'(fw),   32'd2048);
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_gen",  32'(gen),  32'd1);
        check("rst_up",   32'(up),   32'd0);
        check("rst_dn",   32'(dn),   32'd0);
        rst = 1'b0;
        now = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset, then free-running period 32 at fw=2048.
        do_reset(25);
        step_to(15); check("gen_n15", 32'(gen), 32'd1);
        step_to(16); check("gen_n16", 32'(gen), 32'd0);
        step_to(31); check("gen_n31", 32'(gen), 32'd0);
        step_to(32); check("gen_n32", 32'(gen), 32'd1);

        // Loop response: p=22528 lead, p=36834 lag, step 0, hold, max clamp.
        pulse(40, 8'd3,  1'b0, 1'b0, 1'b1, 16'd2045);
        pulse(47, 8'd3,  1'b0, 1'b1, 1'b0, 16'd2048);
        pulse(55, 8'd0,  1'b0, 1'b1, 1'b0, 16'd2048);
        pulse(62, 8'd3,  1'b1, 1'b0, 1'b1, 16'd2048);
        pulse(78, 8'd50, 1'b0, 1'b1, 1'b0, 16'd2098);
        pulse(85, 8'd50, 1'b0, 1'b1, 1'b0, 16'd2100);
        pulse(91, 8'd50, 1'b0, 1'b1, 1'b0, 16'd2100);
        step_to(100); check("fw_max_clamp", 32'(fw), 32'd2100);
        check("lock_scattered", 32'(lock), 32'd0);

        // Lock under hold: edges every 32 cycles land on phase 0.
        do_reset(3);
        for (int k = 1; k <= 16; k++) pulse(32*k - 3, 8'd3, 1'b1, 1'b0, 1'b1, 16'd2048);
        step_to(513); check("lock_before", 32'(lock), 32'd0);
        step_to(514); check("lock_acq",    32'(lock), 32'd1);

        // Reference stops: last edge processed at 513, lock drops at 513+4096.
        step_to(4608); check("to_lock_held", 32'(lock), 32'd1);
        check("to_gen_4608", 32'(gen), 32'd1);
        step_to(4609); check("to_lock_drop", 32'(lock), 32'd0);
        check("to_fw_kept", 32'(fw), 32'd2048);
        step_to(4624); check("to_gen_4624", 32'(gen), 32'd0);

        // Relock, then one out-of-window edge under hold drops lock.
        for (int k = 145; k <= 160; k++) pulse(32*k - 3, 8'd3, 1'b1, 1'b0, 1'b1, 16'd2048);
        step_to(5121); check("relock_before", 32'(lock), 32'd0);
        step_to(5122); check("relock_acq",    32'(lock), 32'd1);
        pulse(5125, 8'd3, 1'b1, 1'b0, 1'b1, 16'd2048);
        step_to(5128); check("hold_lock_held", 32'(lock), 32'd1);
        step_to(5129); check("hold_lock_drop", 32'(lock), 32'd0);
        check("hold_fw", 32'(fw), 32'd2048);

        // Relock, then a single-cycle reset mid-lock.
        for (int k = 162; k <= 177; k++) pulse(32*k - 3, 8'd3, 1'b1, 1'b0, 1'b1, 16'd2048);
        step_to(5666); check("lock_pre_rst", 32'(lock), 32'd1);
        step_to(5670);
        do_reset(1);

        // Re-acquire from FW_INIT, then drive fw down into the FW_MIN clamp.
        for (int k = 1; k <= 16; k++) pulse(32*k - 3, 8'd3, 1'b1, 1'b0, 1'b1, 16'd2048);
        step_to(514); check("reacq_lock", 32'(lock), 32'd1);
        pulse(549, 8'd50, 1'b0, 1'b0, 1'b1, 16'd1998);
        step_to(553); check("minsat_lock_drop", 32'(lock), 32'd0);
        pulse(555, 8'd50, 1'b0, 1'b0, 1'b1, 16'd1950);
        pulse(575, 8'd50, 1'b0, 1'b0, 1'b1, 16'd1950);
        step_to(590); check("fw_min_clamp", 32'(fw), 32'd1950);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
